weight_row_pingpong: RTL

Double-buffered weight row store that sits directly downstream of the BRAM weight reader in the LeNet-5 conv block. It captures one tile of `OCH_T*ICH_T` kernel rows, each `KX` weights wide, streamed as indexed beats. It then presents the whole tile in parallel to the MAC array until the array releases it. Two banks let the reader prefetch the next tile while the array computes on the current one.

---
 rtl/weight_row_pingpong.sv | 129 ++++++++++++
 1 files changed

// File: rtl/weight_row_pingpong.sv
// Double-buffered weight row store. One bank is filled by indexed beats while
// the other is presented in parallel to the MAC array until it is released.
module weight_row_pingpong #(
    parameter  int unsigned OCH_T  = 4,
    parameter  int unsigned ICH_T  = 3,
    parameter  int unsigned KX     = 5,
    parameter  int unsigned W_BW   = 8,
    localparam int unsigned N      = OCH_T * ICH_T,
    localparam int unsigned IDX_BW = $clog2(N),
    localparam int unsigned ROW_W  = KX * W_BW
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [IDX_BW-1:0]     i_wr_idx,
    input  logic [ROW_W-1:0]      i_wr_weight,
    input  logic                  i_wr_valid,
    input  logic                  i_wr_done,
    output logic                  o_wr_ready,
    output logic [N*ROW_W-1:0]    o_weight,
    output logic                  o_valid,
    input  logic                  i_consume,
    output logic [1:0]            o_full_cnt,
    output logic [2:0]            o_err
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_st_e;

    // Extra bit so N itself is representable even when N is a power of two.
    localparam logic [IDX_BW:0] N_EXT = (IDX_BW + 1)'(N);

    bank_st_e            st_q [2];
    bank_st_e            st_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IDX_BW-1:0]   exp_idx_q, exp_idx_d;
    logic [2:0]          err_q, err_d;
    logic [N*ROW_W-1:0]  bank_q [2];

    logic                fill_full;
    logic                idx_ok;
    logic                row_wen;

    // Bank state, pointers, expected index and sticky error register.
    always_ff @(posedge clk) begin
        if (areset) begin
            st_q[0]   <= ST_EMPTY;
            st_q[1]   <= ST_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            exp_idx_q <= '0;
            err_q     <= '0;
        end else begin
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            exp_idx_q <= exp_idx_d;
            err_q     <= err_d;
        end
    end

    // Next-state: fill side on the write bank, release side on the read bank.
    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        exp_idx_d = exp_idx_q;
        err_d     = err_q;
        row_wen   = 1'b0;
        fill_full = (st_q[wr_bank_q] == ST_FULL);
        idx_ok    = ({1'b0, i_wr_idx} < N_EXT);

        if ((i_wr_valid || i_wr_done) && fill_full) begin
            err_d[0] = 1'b1;
        end

        if (i_wr_valid && !fill_full) begin
            exp_idx_d = exp_idx_q + IDX_BW'(1);
            if (!idx_ok || (i_wr_idx != exp_idx_q)) begin
                err_d[1] = 1'b1;
            end
            if (idx_ok) begin
                row_wen = 1'b1;
                if (st_q[wr_bank_q] == ST_EMPTY) begin
                    st_d[wr_bank_q] = ST_FILLING;
                end
            end
        end

        if (i_wr_done && !fill_full) begin
            st_d[wr_bank_q] = ST_FULL;
            wr_bank_d       = ~wr_bank_q;
            exp_idx_d       = '0;
        end

        // A valid release always targets a FULL bank, never the fill bank.
        if (i_consume) begin
            if (st_q[rd_bank_q] == ST_FULL) begin
                st_d[rd_bank_q] = ST_EMPTY;
                rd_bank_d       = ~rd_bank_q;
            end else begin
                err_d[2] = 1'b1;
            end
        end
    end

    // Row storage; released banks keep their data until overwritten.
    always_ff @(posedge clk) begin
        if (areset) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else if (row_wen) begin
            bank_q[wr_bank_q][int'(i_wr_idx) * ROW_W +: ROW_W] <= i_wr_weight;
        end
    end

    // Outputs decoded directly from the bank registers.
    always_comb begin
        o_weight   = bank_q[rd_bank_q];
        o_valid    = (st_q[rd_bank_q] == ST_FULL);
        o_wr_ready = (st_q[wr_bank_q] != ST_FULL);
        o_full_cnt = 2'(st_q[0] == ST_FULL) + 2'(st_q[1] == ST_FULL);
        o_err      = err_q;
    end

endmodule
